// File: rtl/serial_msj_rx.sv
// serial_msj_rx: oversampled UART-style receiver (idle high, 8 data LSB-first, 1 stop) feeding the message register.
// Define SERIAL_PARITY_EN to expect an even-parity bit before stop and expose the parity_err port.
module serial_msj_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef SERIAL_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
`ifdef SERIAL_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic            rs;
  logic            bit_done;
`ifdef SERIAL_PARITY_EN
  logic            perr_reg, perr_next;
  logic            par_bad_reg, par_bad_next;
`endif

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
  end

  assign rs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      perr_reg    <= 1'b0;
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
`ifdef SERIAL_PARITY_EN
      perr_reg    <= perr_next;
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    idx_next     = idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef SERIAL_PARITY_EN
    perr_next    = 1'b0;
    par_bad_next = par_bad_reg;
`endif
    bit_done     = (timer_reg == BIT_END);

    unique case (state_reg)
      IDLE: begin
        if (!rs) begin
          state_next = START;
          timer_next = '0;
        end
      end
      START: begin
        // Re-check at mid start bit so short glitches are discarded.
        if (timer_reg == HALF_END) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = rs ? IDLE : DATA;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_next          = '0;
          shift_next[idx_reg] = rs;
          idx_next            = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          timer_next   = '0;
          par_bad_next = (^shift_reg) ^ rs;
          state_next   = STOP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (bit_done) begin
          timer_next = '0;
          if (rs) begin
            state_next = IDLE;
`ifdef SERIAL_PARITY_EN
            if (par_bad_reg) begin
              perr_next = 1'b1;
            end else begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
`else
            data_next  = shift_reg;
            valid_next = 1'b1;
`endif
          end else begin
            ferr_next  = 1'b1;
            state_next = RECOVER;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      RECOVER: begin
        if (rs) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign data_out   = data_reg;
  assign data_valid = valid_reg;
  assign frame_err  = ferr_reg;
  assign busy       = (state_reg != IDLE);
`ifdef SERIAL_PARITY_EN
  assign parity_err = perr_reg;
`endif

endmodule
